// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the CPU and loader request/ack handshakes, the
// shared RAM port and the arbiter status lines.
// `program` is a reserved word, so the program-mode input is program_mode.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  program_mode;

    logic                  cpu_req;
    logic                  cpu_rw;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  ld_req;
    logic                  ld_rw;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic                  ld_ack;
    logic [DATA_WIDTH-1:0] ld_rdata;

    logic                  mem_en;
    logic                  mem_rw;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic                  owner;

    // Arbiter side: serves the requesters and drives the RAM port.
    modport slave (
        input  program_mode,
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ld_req, ld_rw, ld_addr, ld_wdata,
        output ld_ack, ld_rdata,
        output mem_en, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    // Requester/RAM side: everything the arbiter consumes or produces, mirrored.
    modport master (
        output program_mode,
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ld_req, ld_rw, ld_addr, ld_wdata,
        input  ld_ack, ld_rdata,
        input  mem_en, mem_rw, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the CPU control path and the
// program loader. Requests are sampled only in IDLE, the winner's command is
// latched and held on the RAM port for MEM_LAT cycles, then a one-cycle ack
// returns the read data (zero for writes).
// Optional: define ARB_ROUND_ROBIN_EN to alternate contended grants while
// program_mode is low; otherwise the CPU wins contention in that mode.
module mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_LAT    = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            cnt_q, cnt_d;

    logic                  contended;
    logic                  grant_ld;

`ifdef ARB_ROUND_ROBIN_EN
    logic                  rr_q, rr_d;
`endif

    // Winner selection for an IDLE-cycle grant.
    always_comb begin
        contended = bus.cpu_req && bus.ld_req;
        grant_ld  = 1'b0;
        if (contended) begin
            if (bus.program_mode) begin
                grant_ld = 1'b1;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_ld = rr_q;
`else
                grant_ld = 1'b0;
`endif
            end
        end else begin
            grant_ld = bus.ld_req;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer moves past the requester just granted on each contended grant.
    always_comb begin
        rr_d = rr_q;
        if (state_q == ST_IDLE && contended && !bus.program_mode) begin
            rr_d = ~rr_q;
        end
    end

    // Round-robin pointer register; reset favours the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Next-state logic: latch on grant, count down the access, capture read data.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req || bus.ld_req) begin
                    owner_d = grant_ld;
                    rw_d    = grant_ld ? bus.ld_rw    : bus.cpu_rw;
                    addr_d  = grant_ld ? bus.ld_addr  : bus.cpu_addr;
                    wdata_d = grant_ld ? bus.ld_wdata : bus.cpu_wdata;
                    cnt_d   = LAT_M1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = rw_q ? '0 : bus.mem_rdata;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-command registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode: RAM port only during ACCESS, owner's ack only during DONE.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_rdata = '0;
        bus.ld_ack    = 1'b0;
        bus.ld_rdata  = '0;
        bus.busy      = (state_q != ST_IDLE);
        bus.owner     = owner_q;
        case (state_q)
            ST_ACCESS: begin
                bus.mem_en    = 1'b1;
                bus.mem_rw    = rw_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
            ST_DONE: begin
                if (owner_q) begin
                    bus.ld_ack   = 1'b1;
                    bus.ld_rdata = rdata_q;
                end else begin
                    bus.cpu_ack   = 1'b1;
                    bus.cpu_rdata = rdata_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
